mips_mc_controller: RTL

- Main control FSM for the multicycle MIPS core. It sequences the shared ALU, memory port, instruction register, PC and register file over several cycles per instruction.
- Takes opcode/funct from the instruction register and the R/I-type ALU code from the ALU decoder. It overrides that code during fetch, decode and branch cycles.
- Sits between the instruction register and the datapath muxes. It waits on a variable-latency memory through a ready handshake.

---
 rtl/mips_mc_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mips_mc_controller.sv
// Main control FSM of the multicycle MIPS core: sequences ALU, memory port, IR, PC and register file.
// Optional performance counters (cycle_cnt, retire_cnt) are built when MCCTRL_PERF_EN is defined.
module mips_mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [3:0] aluop_dec,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extop,
  output logic [1:0] pcsrc,
  output logic [3:0] aluop,
  output logic       illegal
`ifdef MCCTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
`endif
);

  localparam logic [3:0] ALU_ADDU = 4'h0;
  localparam logic [3:0] ALU_SUBU = 4'h1;
  localparam logic [3:0] ALU_XXX  = 4'hF;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, EXEC_I, ALUWB, ALUWB_I, BRANCH, JUMP, HALT
  } state_t;

  state_t state, state_n;
  logic   illegal_q;

  // funct is already folded into aluop_dec by the ALU decoder
  logic unused_funct;
  assign unused_funct = ^funct;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == HALT) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    extop    = 1'b0;
    pcsrc    = 2'b00;
    aluop    = ALU_ADDU;
    illegal  = illegal_q;
    // Reset gates every output so an in-flight request drops at once
    if (!reset) begin
      case (state)
        FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            state_n = DECODE;
          end
        end
        DECODE: begin
          alusrcb = 2'b11;
          extop   = 1'b1;
          case (opcode)
            6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011,
            6'b101000, 6'b101001, 6'b101011:                       state_n = MEMADR;
            6'b000000:                                             state_n = EXEC_R;
            6'b001001, 6'b001010, 6'b001011, 6'b001100,
            6'b001101, 6'b001110, 6'b001111:                       state_n = EXEC_I;
            6'b000100, 6'b000101:                                  state_n = BRANCH;
            6'b000010:                                             state_n = JUMP;
            default:                                               state_n = HALT;
          endcase
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          extop   = 1'b1;
          state_n = opcode[3] ? MEMWR : MEMRD;  // stores are 101xxx
        end
        MEMRD: begin
          iord    = 1'b1;
          memread = 1'b1;
          if (mem_ready) state_n = MEMWB;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
          state_n  = FETCH;
        end
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
          if (mem_ready) state_n = FETCH;
        end
        EXEC_R: begin
          alusrca = 1'b1;
          aluop   = aluop_dec;
          state_n = (aluop_dec == ALU_XXX) ? HALT : ALUWB;
        end
        EXEC_I: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = aluop_dec;
          extop   = (opcode[5:2] != 4'b0011);  // logical immediates zero-extend
          state_n = ALUWB_I;
        end
        ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
          state_n  = FETCH;
        end
        ALUWB_I: begin
          regwrite = 1'b1;
          state_n  = FETCH;
        end
        BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALU_SUBU;
          pcsrc   = 2'b01;
          pcwrite = zero ^ opcode[0];  // BNE is BEQ with opcode[0] set
          state_n = FETCH;
        end
        JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
          state_n = FETCH;
        end
        HALT: state_n = HALT;
        default: state_n = FETCH;
      endcase
    end
  end

`ifdef MCCTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt  <= 32'd0;
      retire_cnt <= 32'd0;
    end else begin
      if (state != HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (state_n == FETCH &&
          (state == MEMWB || state == MEMWR || state == ALUWB ||
           state == ALUWB_I || state == BRANCH || state == JUMP))
        retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule
